// File: rtl/crap_pkg.sv
// -----------------------------------------------------------------------------
// crap_pkg
// Shared definitions for the craps roll sequencer:
//   - state_t   : roll sequencer FSM state encoding
//   - DIE_W     : width of one die face (faces 1..6)
//   - SUM_W     : width of the dice sum (2..12)
//   - LFSR_SEED : reset value of the optional die_b LFSR
//   - LFSR_TAPS : feedback mask for the optional LFSR (taps 8,6,5,4)
//   - die_next  : advance a die face 1..6, wrapping 6 -> 1
// -----------------------------------------------------------------------------
package crap_pkg;

    localparam int DIE_W = 3;
    localparam int SUM_W = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Bit n-1 set for tap n: taps 8,6,5,4 -> bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ROLLING   = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_PRESENT   = 3'd3,
        ST_WAIT_GAME = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] d);
        return (d == 3'd6) ? 3'd1 : d + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a stable-time debouncer for the raw
// player button.
//
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous, active-high
//   btn     in  raw button, asynchronous to clk
//   btn_db  out debounced button level
//   press   out one-cycle pulse, high in the first cycle btn_db reads 1
//
// btn_db follows the synchronized level once that level has differed from
// btn_db for DEBOUNCE_CYCLES consecutive cycles, so a rising edge on btn
// reaches btn_db 2 + DEBOUNCE_CYCLES edges later.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn_db,
    output logic press
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [7:0] stable_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_cnt <= '0;
            btn_db     <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == btn_db) begin
                // Any return to the current level restarts the stable window.
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt <= '0;
                btn_db     <= sync2;
                press      <= sync2;
            end else begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/crap_roll_sequencer.sv
// -----------------------------------------------------------------------------
// crap_roll_sequencer
// Sequencing controller in front of the craps game FSM: debounces the player
// button, spins two dice while a roll is in progress, then presents the
// registered dice sum with a one-cycle strobe and waits for the game FSM.
//
// Ports:
//   clk         in  system clock, rising edge
//   reset       in  asynchronous, active-high; clears all state
//   btn         in  raw player button (asynchronous)
//   game_ready  in  level: game FSM wants another roll
//   game_over   in  level: game reached win/lose (wins over game_ready)
//   die_a       out first die face 1..6
//   die_b       out second die face 1..6
//   sum         out registered die_a+die_b, held until the next presentation
//   roll_valid  out one-cycle strobe qualifying sum
//   busy        out high in ROLLING, SETTLE and PRESENT
//   roll_count  out rolls presented since reset, saturating at 255
//   dbg_state   out current FSM state
//
// Handshake: roll_valid is a single-cycle strobe with no back-pressure. The
// game FSM answers with game_ready/game_over levels, which are sampled in
// WAIT_GAME only from the cycle after roll_valid onward, giving the game FSM
// one full cycle to react to the new sum.
//
// Build option CRAP_SEQ_LFSR_EN: when defined, a free-running 8-bit Fibonacci
// LFSR decides when die_b advances during ROLLING instead of the odometer
// carry from die_a.
// -----------------------------------------------------------------------------
module crap_roll_sequencer
    import crap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ROLL_MIN_CYCLES = 8,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic             game_ready,
    input  logic             game_over,
    output logic [DIE_W-1:0] die_a,
    output logic [DIE_W-1:0] die_b,
    output logic [SUM_W-1:0] sum,
    output logic             roll_valid,
    output logic             busy,
    output logic [7:0]       roll_count,
    output state_t           dbg_state
);

    localparam logic [7:0] ROLL_MIN    = 8'(ROLL_MIN_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       btn_db;
    logic       press;
    logic [7:0] roll_cyc;
    logic [7:0] roll_cyc_inc;
    logic [7:0] settle_cnt;
    logic       die_b_step;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .btn_db (btn_db),
        .press  (press)
    );

    // roll_cyc after this cycle's increment, i.e. the number of dice advances
    // including the current cycle. Comparing this against the minimum makes a
    // roll last exactly ROLL_MIN_CYCLES advances when released early.
    assign roll_cyc_inc = (roll_cyc == 8'hFF) ? roll_cyc : roll_cyc + 8'd1;

`ifdef CRAP_SEQ_LFSR_EN
    logic [7:0] lfsr;

    // Runs in every state so the die_b pattern depends on when the roll starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign die_b_step = lfsr[0];
`else
    // Odometer: die_b carries when die_a wraps 6 -> 1.
    assign die_b_step = (die_a == 3'd6);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press) state_nxt = ST_ROLLING;
            end
            ST_ROLLING: begin
                busy = 1'b1;
                if (!btn_db && (roll_cyc_inc >= ROLL_MIN)) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                busy      = 1'b1;
                state_nxt = ST_WAIT_GAME;
            end
            ST_WAIT_GAME: begin
                // The strobe cycle itself is skipped so the game FSM can react.
                if (!roll_valid) begin
                    if (game_over)       state_nxt = ST_DONE;
                    else if (game_ready) state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Dice, counters and presentation registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            roll_cyc   <= '0;
            settle_cnt <= '0;
            die_a      <= 3'd1;
            die_b      <= 3'd1;
            sum        <= '0;
            roll_valid <= 1'b0;
            roll_count <= '0;
        end else begin
            roll_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    roll_cyc <= '0;
                end
                ST_ROLLING: begin
                    roll_cyc   <= roll_cyc_inc;
                    settle_cnt <= '0;
                    die_a      <= die_next(die_a);
                    if (die_b_step) die_b <= die_next(die_b);
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                end
                ST_PRESENT: begin
                    sum        <= {1'b0, die_a} + {1'b0, die_b};
                    roll_valid <= 1'b1;
                    if (roll_count != 8'hFF) roll_count <= roll_count + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
